// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared Bridge bus: alternating priority when both
// masters contend, with a burst limit on how long one master can hold the bus.
module bus_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_served;
  logic [3:0] burst_cnt;
  logic       burst_done;

  // ">=" keeps the limit effective even when the count ran past it while
  // the current owner was the only requester.
  assign burst_done = (burst_cnt >= BURST_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last_served ? GNT0 : GNT1;
        else if (m0_req)      state_nxt = GNT0;
        else if (m1_req)      state_nxt = GNT1;
        else                  state_nxt = IDLE;
      end
      GNT0: begin
        if (!m0_req)                   state_nxt = m1_req ? GNT1 : IDLE;
        else if (m1_req && burst_done) state_nxt = GNT1;
        else                           state_nxt = GNT0;
      end
      GNT1: begin
        if (!m1_req)                   state_nxt = m0_req ? GNT0 : IDLE;
        else if (m0_req && burst_done) state_nxt = GNT0;
        else                           state_nxt = GNT1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      burst_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        burst_cnt <= '0;
        if (state == GNT0) last_served <= 1'b0;
        if (state == GNT1) last_served <= 1'b1;
      end else if ((state == GNT0 && m0_req) || (state == GNT1 && m1_req)) begin
        if (burst_cnt != 4'd15) burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    Bus_addr  = '0;
    Bus_wen   = 1'b0;
    Bus_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    unique case (state)
      GNT0: begin
        Bus_addr  = m0_addr;
        Bus_wen   = m0_req & m0_wen;
        Bus_wdata = m0_wdata;
        m0_ack    = m0_req;
        m0_rdata  = m0_req ? Bus_rdata : '0;
      end
      GNT1: begin
        Bus_addr  = m1_addr;
        Bus_wen   = m1_req & m1_wen;
        Bus_wdata = m1_wdata;
        m1_ack    = m1_req;
        m1_rdata  = m1_req ? Bus_rdata : '0;
      end
      default: ;
    endcase
  end

  assign owner = state;

endmodule
